// File: rtl/calc_alu_sequencer.sv
// calc_alu_sequencer: multi-cycle add/sub/mul/div controller on a shared iterative datapath
module calc_alu_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ack,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Remainder,
    output logic             Flag,
    output logic             Err
);
    typedef enum logic [6:0] {
        S_IDLE = 7'b0000001,
        S_ADD  = 7'b0000010,
        S_SUB  = 7'b0000100,
        S_MUL  = 7'b0001000,
        S_DIV  = 7'b0010000,
        S_ERR  = 7'b0100000,
        S_DONE = 7'b1000000
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               flag_q, flag_d;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   trial_sub;
    logic               trial_ge;
    logic [2*WIDTH-1:0] mul_acc;
    logic [2*WIDTH-1:0] div_acc;
    logic               last;

    assign sum       = {1'b0, x_q[WIDTH-1:0]} + {1'b0, y_q};
    // Partial remainder shifted left with the next dividend bit; needs one extra bit.
    assign trial     = acc_q[2*WIDTH-1:WIDTH-1];
    assign trial_ge  = trial >= {1'b0, y_q};
    assign trial_sub = trial[WIDTH-1:0] - y_q;
    assign div_acc   = {trial_ge ? trial_sub : trial[WIDTH-1:0], acc_q[WIDTH-2:0], trial_ge};
    assign mul_acc   = acc_q + (y_q[0] ? x_q : '0);
    assign last      = cnt_q == CNT_W'(WIDTH - 1);

    assign Busy      = (state_q == S_ADD) || (state_q == S_SUB) || (state_q == S_MUL) || (state_q == S_DIV);
    assign Done      = (state_q == S_DONE) || (state_q == S_ERR);
    assign Err       = state_q == S_ERR;
    assign Result    = res_q;
    assign Remainder = rem_q;
    assign Flag      = flag_q;

    // Next-state and datapath step selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        res_d   = res_q;
        rem_d   = rem_q;
        flag_d  = flag_q;
        case (state_q)
            S_IDLE: if (Start) begin
                x_d     = {{WIDTH{1'b0}}, A};
                y_d     = B;
                acc_d   = Op == 2'b11 ? {{WIDTH{1'b0}}, A} : '0;
                cnt_d   = '0;
                res_d   = '0;
                rem_d   = '0;
                flag_d  = 1'b0;
                state_d = Op == 2'b00 ? S_ADD :
                          Op == 2'b01 ? S_SUB :
                          Op == 2'b10 ? S_MUL :
                          B == '0     ? S_ERR : S_DIV;
            end
            S_ADD: begin
                res_d   = sum[WIDTH-1:0];
                flag_d  = sum[WIDTH];
                state_d = S_DONE;
            end
            S_SUB: begin
                res_d   = x_q[WIDTH-1:0] - y_q;
                flag_d  = x_q[WIDTH-1:0] < y_q;
                state_d = S_DONE;
            end
            S_MUL: begin
                acc_d   = mul_acc;
                x_d     = x_q << 1;
                y_d     = y_q >> 1;
                cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
                res_d   = last ? mul_acc[WIDTH-1:0] : res_q;
                flag_d  = last ? |mul_acc[2*WIDTH-1:WIDTH] : flag_q;
                state_d = last ? S_DONE : S_MUL;
            end
            S_DIV: begin
                acc_d   = div_acc;
                cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
                res_d   = last ? div_acc[WIDTH-1:0] : res_q;
                rem_d   = last ? div_acc[2*WIDTH-1:WIDTH] : rem_q;
                state_d = last ? S_DONE : S_DIV;
            end
            S_ERR, S_DONE: state_d = Ack ? S_IDLE : state_q;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            rem_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            rem_q   <= rem_d;
            flag_q  <= flag_d;
        end
    end
endmodule

// File: tb/tb_calc_alu_sequencer.sv
// tb_calc_alu_sequencer: directed vectors for the calculator ALU sequencer
module tb_calc_alu_sequencer;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        Ack = 1'b0;
    logic        Busy, Done, Flag, Err;
    logic [15:0] Result, Remainder;
    int          tests = 0;
    int          fails = 0;
    int          n;

    calc_alu_sequencer #(.WIDTH(16), .CNT_W(5)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B), .Ack(Ack),
        .Busy(Busy), .Done(Done), .Result(Result), .Remainder(Remainder), .Flag(Flag), .Err(Err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse Start for one edge, then scramble the inputs to prove only latched copies are used.
    task automatic start_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        Op = op; A = a; B = b; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0; Op = 2'($urandom); A = 16'($urandom); B = 16'($urandom);
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (!Done && cnt < 40) begin
            @(negedge Clk);
            cnt++;
        end
    endtask

    task automatic ack_it(input string tag);
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        chk({tag, "_done_fall"}, Done, 0);
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input int lat, input logic [15:0] res, input logic [15:0] rem, input logic fl, input logic er);
        int c;
        start_op(op, a, b);
        wait_done(c);
        chk({tag, "_lat"}, c, lat);
        chk({tag, "_res"}, Result, res);
        chk({tag, "_rem"}, Remainder, rem);
        chk({tag, "_flag"}, Flag, fl);
        chk({tag, "_err"}, Err, er);
        ack_it(tag);
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_res", Result, 0);
        chk("rst_flag", Flag, 0);
        Reset = 1'b0;
        @(negedge Clk);

        run("add_carry", 2'b00, 16'hFFFF, 16'h0001, 1, 16'h0000, 16'h0, 1'b1, 1'b0);
        run("add_plain", 2'b00, 16'd3, 16'd4, 1, 16'd7, 16'h0, 1'b0, 1'b0);
        run("sub_borrow", 2'b01, 16'd5, 16'd7, 1, 16'hFFFE, 16'h0, 1'b1, 1'b0);
        run("sub_plain", 2'b01, 16'd7, 16'd5, 1, 16'h0002, 16'h0, 1'b0, 1'b0);
        run("mul_300x200", 2'b10, 16'd300, 16'd200, 16, 16'hEA60, 16'h0, 1'b0, 1'b0);
        run("mul_ovf", 2'b10, 16'h0100, 16'h0100, 16, 16'h0000, 16'h0, 1'b1, 1'b0);
        run("mul_max", 2'b10, 16'hFFFF, 16'hFFFF, 16, 16'h0001, 16'h0, 1'b1, 1'b0);
        run("div_1000_7", 2'b11, 16'd1000, 16'd7, 16, 16'd142, 16'd6, 1'b0, 1'b0);
        run("div_big", 2'b11, 16'hFFFF, 16'h8001, 16, 16'h0001, 16'h7FFE, 1'b0, 1'b0);
        run("div_small", 2'b11, 16'd3, 16'd9, 16, 16'd0, 16'd3, 1'b0, 1'b0);
        run("div_zero", 2'b11, 16'd5, 16'd0, 0, 16'd0, 16'd0, 1'b0, 1'b1);

        start_op(2'b10, 16'd300, 16'd200);
        chk("mul_busy", Busy, 1);
        repeat (7) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("midrst_busy", Busy, 0);
        chk("midrst_done", Done, 0);
        chk("midrst_res", Result, 0);
        chk("midrst_rem", Remainder, 0);
        chk("midrst_flag", Flag, 0);
        chk("midrst_err", Err, 0);
        run("post_rst_add", 2'b00, 16'd10, 16'd20, 1, 16'd30, 16'h0, 1'b0, 1'b0);

        start_op(2'b10, 16'd3, 16'd5);
        Op = 2'b00; A = 16'd1; B = 16'd1; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        wait_done(n);
        chk("busy_start_lat", n, 15);
        chk("busy_start_res", Result, 15);
        ack_it("busy_start");
        chk("busy_start_idle", Busy, 0);

        start_op(2'b00, 16'd3, 16'd4);
        wait_done(n);
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            chk("hold_done", Done, 1);
            chk("hold_res", Result, 7);
        end
        Op = 2'b01; A = 16'd10; B = 16'd2; Start = 1'b1; Ack = 1'b1;
        @(negedge Clk);
        Start = 1'b0; Ack = 1'b0;
        chk("sa_done", Done, 0);
        chk("sa_busy", Busy, 0);
        chk("sa_res_kept", Result, 7);
        @(negedge Clk);
        chk("sa_still_idle", Busy, 0);
        run("sa_next", 2'b01, 16'd10, 16'd2, 1, 16'd8, 16'h0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
